// File: rtl/cp0.sv
// MIPS-style coprocessor 0: status/cause/EPC, exception commit and interrupt request.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read as 0.
module cp0 #(
   parameter logic [31:0] PRID = 32'h0001_8000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_cp0_r_addr,
   output logic [31:0] ex_cp0_r_data,
   input  logic        ex_cp0_w_ena,
   input  logic [4:0]  ex_cp0_w_addr,
   input  logic [31:0] ex_cp0_w_data,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic        exc_bd,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret,
   input  logic [5:0]  ext_int,
   output logic [31:0] cp0_status,
   output logic [31:0] cp0_cause,
   output logic [31:0] cp0_epc,
   output logic        int_req
);

   localparam logic [4:0] A_BADV = 5'd8;
   localparam logic [4:0] A_CNT  = 5'd9;
   localparam logic [4:0] A_CMP  = 5'd11;
   localparam logic [4:0] A_STAT = 5'd12;
   localparam logic [4:0] A_CAUS = 5'd13;
   localparam logic [4:0] A_EPC  = 5'd14;
   localparam logic [4:0] A_PRID = 5'd15;

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic        ti_q, ti_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badv_q, badv_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        tick_q, tick_d;

   logic wr_stat, wr_caus, wr_epc;
   logic [7:0] ip;

   assign wr_stat = ex_cp0_w_ena && (ex_cp0_w_addr == A_STAT);
   assign wr_caus = ex_cp0_w_ena && (ex_cp0_w_addr == A_CAUS);
   assign wr_epc  = ex_cp0_w_ena && (ex_cp0_w_addr == A_EPC);

   always_comb begin
      im_d      = im_q;
      ie_d      = ie_q;
      exl_d     = exl_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      badv_d    = badv_q;
      ip_hw_d   = ext_int;
      ip_sw_d   = ip_sw_q;
      if (wr_stat) begin
         im_d  = ex_cp0_w_data[15:8];
         ie_d  = ex_cp0_w_data[0];
         exl_d = ex_cp0_w_data[1];
      end
      if (wr_caus) ip_sw_d = ex_cp0_w_data[9:8];
      if (wr_epc) epc_d = ex_cp0_w_data;
      // Later assignments win: exception over ERET over MTC0.
      if (eret) exl_d = 1'b0;
      if (exc_valid) begin
         exl_d     = 1'b1;
         exccode_d = exc_code;
         if (!exl_q) begin
            epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
            bd_d  = exc_bd;
         end
         if (exc_code == 5'h04 || exc_code == 5'h05)
            badv_d = exc_badvaddr;
      end
   end

`ifdef CP0_TIMER_EN
   logic wr_cnt, wr_cmp;
   assign wr_cnt = ex_cp0_w_ena && (ex_cp0_w_addr == A_CNT);
   assign wr_cmp = ex_cp0_w_ena && (ex_cp0_w_addr == A_CMP);

   always_comb begin
      tick_d    = ~tick_q;
      count_d   = tick_q ? count_q + 32'd1 : count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (wr_cnt) begin
         count_d = ex_cp0_w_data;
         tick_d  = 1'b0;
      end
      if (wr_cmp) begin
         compare_d = ex_cp0_w_data;
         ti_d      = 1'b0;
      end else if (count_d == compare_q && compare_q != 32'd0) begin
         ti_d = 1'b1;
      end
   end
`else
   always_comb begin
      tick_d    = 1'b0;
      count_d   = 32'd0;
      compare_d = 32'd0;
      ti_d      = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         im_q      <= '0;
         ie_q      <= 1'b0;
         exl_q     <= 1'b0;
         bd_q      <= 1'b0;
         ti_q      <= 1'b0;
         ip_hw_q   <= '0;
         ip_sw_q   <= '0;
         exccode_q <= '0;
         epc_q     <= '0;
         badv_q    <= '0;
         count_q   <= '0;
         compare_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         im_q      <= im_d;
         ie_q      <= ie_d;
         exl_q     <= exl_d;
         bd_q      <= bd_d;
         ti_q      <= ti_d;
         ip_hw_q   <= ip_hw_d;
         ip_sw_q   <= ip_sw_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
         badv_q    <= badv_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         tick_q    <= tick_d;
      end
   end

   assign ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

   assign cp0_status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cp0_cause  = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};
   assign cp0_epc    = epc_q;
   assign int_req    = ie_q & ~exl_q & (|(ip & im_q));

   always_comb begin
      case (ex_cp0_r_addr)
         A_BADV:  ex_cp0_r_data = badv_q;
         A_CNT:   ex_cp0_r_data = count_q;
         A_CMP:   ex_cp0_r_data = compare_q;
         A_STAT:  ex_cp0_r_data = cp0_status;
         A_CAUS:  ex_cp0_r_data = cp0_cause;
         A_EPC:   ex_cp0_r_data = epc_q;
         A_PRID:  ex_cp0_r_data = PRID;
         default: ex_cp0_r_data = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
// Timer scenario runs only when CP0_TIMER_EN is defined.
module tb_cp0;

   logic        clk;
   logic        rst;
   logic [4:0]  r_addr;
   logic [31:0] r_data;
   logic        w_ena;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic        exc_bd;
   logic [31:0] exc_pc;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [5:0]  ext_int;
   logic [31:0] status, cause, epc;
   logic        int_req;

   int checks = 0;
   int errors = 0;

   cp0 dut (
      .clk(clk), .rst(rst),
      .ex_cp0_r_addr(r_addr), .ex_cp0_r_data(r_data),
      .ex_cp0_w_ena(w_ena), .ex_cp0_w_addr(w_addr),
      .ex_cp0_w_data(w_data),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd),
      .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr),
      .eret(eret), .ext_int(ext_int),
      .cp0_status(status), .cp0_cause(cause), .cp0_epc(epc),
      .int_req(int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      w_ena = 0; w_addr = 0; w_data = 0;
      exc_valid = 0; exc_code = 0; exc_bd = 0;
      exc_pc = 0; exc_badvaddr = 0; eret = 0;
   endtask

   task automatic rd(input logic [4:0] a);
      r_addr = a;
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] addrs [5];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd13, 5'd14};
      checks++;
      if (status !== 32'h0040_0000) begin
         errors++;
         $display("FAIL reset_status got %h want 00400000", status);
      end
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_int_req got %b want 0", int_req);
      end
      foreach (addrs[i]) begin
         rd(addrs[i]);
         checks++;
         if (r_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_reg%0d got %h want 0", addrs[i], r_data);
         end
      end
      rd(5'd15);
      checks++;
      if (r_data !== 32'h0001_8000) begin
         errors++;
         $display("FAIL prid got %h want 00018000", r_data);
      end
   endtask

   task automatic test_mtc0_int();
      ext_int = 6'b000001;
      w_ena = 1; w_addr = 5'd12; w_data = 32'h0000_FF01;
      rd(5'd12);
      checks++;
      if (r_data !== 32'h0040_0000) begin
         errors++;
         $display("FAIL same_cycle_read got %h want 00400000", r_data);
      end
      step(1);
      idle();
      rd(5'd12);
      checks++;
      if (r_data !== 32'h0040_FF01) begin
         errors++;
         $display("FAIL status_write got %h want 0040ff01", r_data);
      end
      checks++;
      if (cause[10] !== 1'b1 || int_req !== 1'b1) begin
         errors++;
         $display("FAIL hw_int got ip10=%b req=%b want 1 1", cause[10], int_req);
      end
      ext_int = 6'b0;
      step(1);
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL int_drop got %b want 0", int_req);
      end
   endtask

   task automatic test_exception();
      exc_valid = 1; exc_code = 5'h04; exc_bd = 1;
      exc_pc = 32'h8000_0010; exc_badvaddr = 32'h1234_5679;
      step(1);
      idle();
      checks++;
      if (epc !== 32'h8000_000C) begin
         errors++;
         $display("FAIL exc_epc got %h want 8000000c", epc);
      end
      checks++;
      if (cause !== 32'h8000_0010) begin
         errors++;
         $display("FAIL exc_cause got %h want 80000010", cause);
      end
      rd(5'd8);
      checks++;
      if (r_data !== 32'h1234_5679) begin
         errors++;
         $display("FAIL exc_badvaddr got %h want 12345679", r_data);
      end
      checks++;
      if (status !== 32'h0040_FF03 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL exc_status got %h req=%b want 0040ff03 0", status, int_req);
      end
   endtask

   task automatic test_nested_exc();
      exc_valid = 1; exc_code = 5'h0A; exc_bd = 0;
      exc_pc = 32'hBFC0_0000; exc_badvaddr = 32'hDEAD_BEEF;
      step(1);
      idle();
      checks++;
      if (epc !== 32'h8000_000C) begin
         errors++;
         $display("FAIL nested_epc got %h want 8000000c", epc);
      end
      checks++;
      if (cause !== 32'h8000_0028) begin
         errors++;
         $display("FAIL nested_cause got %h want 80000028", cause);
      end
      rd(5'd8);
      checks++;
      if (r_data !== 32'h1234_5679) begin
         errors++;
         $display("FAIL nested_badvaddr got %h want 12345679", r_data);
      end
   endtask

   task automatic test_eret();
      eret = 1;
      step(1);
      idle();
      checks++;
      if (status !== 32'h0040_FF01) begin
         errors++;
         $display("FAIL eret_status got %h want 0040ff01", status);
      end
   endtask

   task automatic test_priority();
      exc_valid = 1; exc_code = 5'h00; exc_bd = 0; exc_pc = 32'h0000_0100;
      eret = 1;
      w_ena = 1; w_addr = 5'd12; w_data = 32'h0000_0A00;
      step(1);
      idle();
      checks++;
      if (status !== 32'h0040_0A02) begin
         errors++;
         $display("FAIL prio_status got %h want 00400a02", status);
      end
      checks++;
      if (epc !== 32'h0000_0100 || cause !== 32'h0) begin
         errors++;
         $display("FAIL prio_epc_cause got %h %h want 00000100 00000000", epc, cause);
      end
   endtask

   task automatic test_misc();
      w_ena = 1; w_addr = 5'd13; w_data = 32'hFFFF_FFFF;
      step(1);
      w_addr = 5'd3; w_data = 32'h5555_5555;
      step(1);
      w_addr = 5'd15; w_data = 32'h0;
      step(1);
      w_addr = 5'd14; w_data = 32'hCAFE_0004;
      step(1);
      idle();
      checks++;
      if (cause !== 32'h0000_0300) begin
         errors++;
         $display("FAIL cause_sw got %h want 00000300", cause);
      end
      rd(5'd3);
      checks++;
      if (r_data !== 32'd0) begin
         errors++;
         $display("FAIL unimpl_read got %h want 0", r_data);
      end
      rd(5'd15);
      checks++;
      if (r_data !== 32'h0001_8000) begin
         errors++;
         $display("FAIL prid_ro got %h want 00018000", r_data);
      end
      checks++;
      if (epc !== 32'hCAFE_0004) begin
         errors++;
         $display("FAIL epc_write got %h want cafe0004", epc);
      end
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      w_ena = 1; w_addr = 5'd11; w_data = 32'd3;
      step(1);
      w_addr = 5'd9; w_data = 32'd0;
      step(1);
      idle();
      step(5);
      checks++;
      if (cause[30] !== 1'b0) begin
         errors++;
         $display("FAIL ti_early got %b want 0", cause[30]);
      end
      step(1);
      rd(5'd9);
      checks++;
      if (cause[30] !== 1'b1 || cause[15] !== 1'b1 || r_data !== 32'd3) begin
         errors++;
         $display("FAIL ti_set got ti=%b ip15=%b cnt=%h want 1 1 3",
                  cause[30], cause[15], r_data);
      end
      w_ena = 1; w_addr = 5'd11; w_data = 32'h0000_1000;
      step(1);
      idle();
      checks++;
      if (cause[30] !== 1'b0) begin
         errors++;
         $display("FAIL ti_clear got %b want 0", cause[30]);
      end
      w_ena = 1; w_addr = 5'd9; w_data = 32'hFFFF_FFFF;
      step(1);
      idle();
      step(1);
      rd(5'd9);
      checks++;
      if (r_data !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL count_hold got %h want ffffffff", r_data);
      end
      step(1);
      rd(5'd9);
      checks++;
      if (r_data !== 32'd0) begin
         errors++;
         $display("FAIL count_wrap got %h want 0", r_data);
      end
   endtask
`else
   task automatic test_timer();
      w_ena = 1; w_addr = 5'd9; w_data = 32'd5;
      step(1);
      w_addr = 5'd11; w_data = 32'd5;
      step(1);
      idle();
      step(2);
      rd(5'd9);
      checks++;
      if (r_data !== 32'd0) begin
         errors++;
         $display("FAIL count_off got %h want 0", r_data);
      end
      rd(5'd11);
      checks++;
      if (r_data !== 32'd0 || cause[30] !== 1'b0) begin
         errors++;
         $display("FAIL compare_off got %h ti=%b want 0 0", r_data, cause[30]);
      end
   endtask
`endif

   task automatic test_async_reset();
      w_ena = 1; w_addr = 5'd12; w_data = 32'h0000_FF03;
      step(1);
      exc_valid = 1; exc_code = 5'h05; exc_pc = 32'h4;
      exc_badvaddr = 32'h7777_0000;
      #2;
      rst = 0;
      #1;
      checks++;
      if (status !== 32'h0040_0000 || epc !== 32'd0 || cause !== 32'd0) begin
         errors++;
         $display("FAIL async_reset got %h %h %h want 00400000 0 0",
                  status, epc, cause);
      end
      step(1);
      rd(5'd8);
      checks++;
      if (r_data !== 32'd0 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort got %h req=%b want 0 0", r_data, int_req);
      end
      idle();
      rst = 1;
      step(1);
   endtask

   initial begin
      idle();
      ext_int = 0;
      r_addr = 0;
      rst = 0;
      step(2);
      test_reset();
      rst = 1;
      step(1);
      test_mtc0_int();
      test_exception();
      test_nested_exc();
      test_eret();
      test_priority();
      test_misc();
      test_timer();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The block SHALL have one parameter: PRID, default 32'h0001_8000, the read-only value returned for register 15 (PRId).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port ex_cp0_r_addr, input, 5, the read register number.
REQ-005 The block SHALL have port ex_cp0_r_data, output, 32, the read data (combinational from registered state).
REQ-006 The block SHALL have ports ex_cp0_w_ena (input, 1), ex_cp0_w_addr (input, 5) and ex_cp0_w_data (input, 32), the MTC0 write request.
REQ-007 The block SHALL have ports exc_valid (input, 1), exc_code (input, 5), exc_bd (input, 1), exc_pc (input, 32) and exc_badvaddr (input, 32), the exception commit from the pipeline.
REQ-008 The block SHALL have port eret, input, 1, the ERET commit.
REQ-009 The block SHALL have port ext_int, input, 6, the hardware interrupt levels.
REQ-010 The block SHALL have ports cp0_status, cp0_cause and cp0_epc, each output, 32, the current register values.
REQ-011 The block SHALL have port int_req, output, 1, the pending-interrupt request.

Function
REQ-012 The implemented registers SHALL be: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14) and PRId(15); any other address SHALL read 32'h0, and writes to it SHALL be ignored.
REQ-013 A read SHALL have zero latency and return the pre-edge value, so a same-cycle write is not visible until the next cycle.
REQ-014 A write SHALL take effect at the next edge; writable fields are Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; all of EPC, Count and Compare; BadVAddr and PRId are read-only.
REQ-015 Status[22] (BEV) SHALL read as the constant 1; all other unlisted bits SHALL read 0.
REQ-016 Cause IP[15:10] SHALL be resampled every cycle from ext_int[5:0], with IP[15] = ext_int[5] OR Cause.TI[30].
REQ-017 On exc_valid with Status.EXL=0, the block SHALL set EPC = exc_bd ? exc_pc-4 : exc_pc and set Cause.BD[31] = exc_bd.
REQ-018 On exc_valid with Status.EXL=1, EPC and Cause.BD SHALL remain unchanged.
REQ-019 On every exc_valid, the block SHALL set Status.EXL=1 and Cause.ExcCode[6:2]=exc_code.
REQ-020 The block SHALL load BadVAddr from exc_badvaddr only when exc_code is 5'h04 (AdEL) or 5'h05 (AdES).
REQ-021 On eret without exc_valid, the block SHALL clear Status.EXL.
REQ-022 Same-cycle priority SHALL be exc_valid > eret > MTC0 for any field they share; non-conflicting fields of the MTC0 SHALL still be written.
REQ-023 int_req SHALL equal Status.IE AND NOT Status.EXL AND OR(Cause.IP[15:8] AND Status.IM[15:8]), derived combinationally from registers.

Reset
REQ-024 While rst=0, the block SHALL immediately force Count, Compare, EPC, BadVAddr, Cause and the tick toggle to 0, and Status to 32'h0040_0000, giving int_req=0.
REQ-025 Assertion of rst mid-operation SHALL abort any pending timer match or exception update.

Configuration
REQ-026 With CP0_TIMER_EN defined, a tick toggle SHALL flip each cycle, and Count SHALL increment (wrapping at 2^32) on cycles where the toggle is 1.
REQ-027 With CP0_TIMER_EN defined, TI SHALL set when Count==Compare after the update and Compare!=0.
REQ-028 With CP0_TIMER_EN defined, a Compare write SHALL clear TI, winning over a same-cycle match.
REQ-029 With CP0_TIMER_EN defined, a Count write SHALL win over the increment and SHALL reset the toggle.
REQ-030 Without CP0_TIMER_EN, Count and Compare SHALL read 0, writes to them SHALL be ignored, and TI SHALL be constant 0.

Verification
REQ-031 The bench SHALL check: reset -> Status=32'h0040_0000, all other registers 0, int_req=0; a read of address 15 -> PRID.
REQ-032 The bench SHALL check: MTC0 Status=32'h0000_FF01 with ext_int=6'b000001 -> the next cycle Cause[10]=1 and int_req=1; a same-cycle read returns the old Status.
REQ-033 The bench SHALL check: exc_valid with code 5'h04, bd=1, pc=32'h8000_0010, badvaddr=32'h1234_5679 -> EPC=32'h8000_000C, Cause=32'h8000_0010 (BD and ExcCode set), BadVAddr updated and EXL=1.
REQ-034 The bench SHALL check: a second exception with EXL=1 and pc=32'hBFC0_0000 -> EPC unchanged and ExcCode updated.
REQ-035 The bench SHALL check: exc_valid together with eret and an MTC0 Status EXL=0 in the same cycle -> EXL=1 and the MTC0 IM bits still written.
REQ-036 The bench SHALL check (CP0_TIMER_EN): Compare=3 and Count=0 written -> TI=1 after 6 cycles; a Compare rewrite -> TI=0; Count=32'hFFFF_FFFF -> wraps to 0 after 2 cycles.
